// File: rtl/ifm_buf_loader.sv
// IFM row loader: fetches one image row from DRAM in bursts and writes it into
// a ring of line-buffer banks; rows below the image are zero-filled locally.
module ifm_buf_loader #(
  parameter int W_SIZE      = 9,
  parameter int W_CHANNEL   = 5,
  parameter int IFM_BUF_CNT = 4,
  parameter int W_IFM_BUF   = 2,
  parameter int W_DATA      = 32,
  parameter int W_ADDR      = 32,
  parameter int W_BUF_ADDR  = 10,
  parameter int BPW         = 4,
  parameter int MAX_BURST   = 256,
  parameter int W_LEN       = 9
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_req_load,
  input  logic [W_SIZE-1:0]      i_req_row,
  input  logic [W_SIZE-1:0]      i_width,
  input  logic [W_SIZE-1:0]      i_height,
  input  logic [W_CHANNEL-1:0]   i_chn,
  input  logic [W_ADDR-1:0]      i_base_addr,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [W_IFM_BUF-1:0]   o_bank,
  output logic                   o_rd_req,
  input  logic                   i_rd_ack,
  output logic [W_ADDR-1:0]      o_rd_addr,
  output logic [W_LEN-1:0]       o_rd_len,
  input  logic                   i_rd_valid,
  output logic                   o_rd_ready,
  input  logic [W_DATA-1:0]      i_rd_data,
  output logic [IFM_BUF_CNT-1:0] o_buf_we,
  output logic [W_BUF_ADDR-1:0]  o_buf_addr,
  output logic [W_DATA-1:0]      o_buf_wdata,
  output logic [2:0]             o_dbg_state
);

  localparam int W_TOT = W_SIZE + W_CHANNEL;

  // Handshakes: a read command transfers on the cycle o_rd_req & i_rd_ack are both
  // high, with o_rd_addr/o_rd_len held stable until then; a data beat transfers on
  // every cycle i_rd_valid & o_rd_ready are both high.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_CMD  = 3'd2,
    S_DATA = 3'd3,
    S_ZERO = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [W_SIZE-1:0]      row_q;
  logic [W_ADDR-1:0]      base_q;
  logic [W_TOT-1:0]       total_q;
  logic [W_IFM_BUF-1:0]   bank_q;
  logic [W_ADDR-1:0]      addr_q;
  logic [W_TOT-1:0]       issued_q;
  logic [W_TOT-1:0]       wcnt_q;
  logic [W_LEN-1:0]       beats_q;
  logic [IFM_BUF_CNT-1:0] we_q;
  logic [W_BUF_ADDR-1:0]  baddr_q;
  logic [W_DATA-1:0]      wdata_q;

  logic [W_TOT-1:0]       rem;
  logic [W_LEN-1:0]       burst_len;
  logic [IFM_BUF_CNT-1:0] bank_onehot;
  logic                   beat_acc;
  logic                   last_beat;
  logic                   zero_last;

  // Words not yet covered by an issued command decide the next burst size.
  assign rem         = total_q - issued_q;
  assign burst_len   = (rem > W_TOT'(MAX_BURST)) ? W_LEN'(MAX_BURST) : W_LEN'(rem);
  assign bank_onehot = IFM_BUF_CNT'(1) << bank_q;
  assign beat_acc    = (state_q == S_DATA) && i_rd_valid;
  assign last_beat   = beat_acc && (beats_q == W_LEN'(1));
  assign zero_last   = (total_q == '0) || (wcnt_q == total_q - W_TOT'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_load) begin
          state_d = (i_req_row >= i_height) ? S_ZERO : S_CALC;
        end
      end
      S_CALC: state_d = (total_q == '0) ? S_DONE : S_CMD;
      S_CMD: begin
        if (i_rd_ack) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (last_beat) begin
          state_d = (issued_q == total_q) ? S_DONE : S_CMD;
        end
      end
      S_ZERO: begin
        if (zero_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (state_q != S_IDLE);
    o_done      = (state_q == S_DONE);
    o_rd_req    = (state_q == S_CMD);
    o_rd_ready  = (state_q == S_DATA);
    o_rd_addr   = '0;
    o_rd_len    = '0;
    o_dbg_state = state_q;
    if (state_q == S_CMD) begin
      o_rd_addr = addr_q;
      o_rd_len  = burst_len;
    end
  end

  // Datapath: request latching, address/count bookkeeping and the registered
  // write port, which trails beat acceptance by one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q    <= '0;
      base_q   <= '0;
      total_q  <= '0;
      bank_q   <= '0;
      addr_q   <= '0;
      issued_q <= '0;
      wcnt_q   <= '0;
      beats_q  <= '0;
      we_q     <= '0;
      baddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      we_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (i_req_load) begin
            row_q    <= i_req_row;
            base_q   <= i_base_addr;
            total_q  <= W_TOT'(i_width) * W_TOT'(i_chn);
            bank_q   <= i_req_row[W_IFM_BUF-1:0];
            wcnt_q   <= '0;
            issued_q <= '0;
          end
        end
        S_CALC: begin
          addr_q   <= base_q + W_ADDR'(row_q) * W_ADDR'(total_q) * W_ADDR'(BPW);
          wcnt_q   <= '0;
          issued_q <= '0;
        end
        S_CMD: begin
          if (i_rd_ack) begin
            addr_q   <= addr_q + W_ADDR'(burst_len) * W_ADDR'(BPW);
            issued_q <= issued_q + W_TOT'(burst_len);
            beats_q  <= burst_len;
          end
        end
        S_DATA: begin
          if (beat_acc) begin
            we_q    <= bank_onehot;
            baddr_q <= wcnt_q[W_BUF_ADDR-1:0];
            wdata_q <= i_rd_data;
            wcnt_q  <= wcnt_q + W_TOT'(1);
            beats_q <= beats_q - W_LEN'(1);
          end
        end
        S_ZERO: begin
          if (total_q != '0) begin
            we_q    <= bank_onehot;
            baddr_q <= wcnt_q[W_BUF_ADDR-1:0];
            wdata_q <= '0;
            wcnt_q  <= wcnt_q + W_TOT'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_bank      = bank_q;
  assign o_buf_we    = we_q;
  assign o_buf_addr  = baddr_q;
  assign o_buf_wdata = wdata_q;

endmodule

// File: doc/ifm_buf_loader.md
Name: ifm_buf_loader

Overview:
- DRAM-to-BRAM row loader for the IFM line buffers.
- Sits directly downstream of cnn_ctrl's row-load request (o_ifm_buf_req_load / o_ifm_buf_req_row) and feeds its q_ifm_buf_done.
- Per request, fetches one IFM row (width × tiled channels words) from DRAM in bursts and writes it into one of IFM_BUF_CNT ring banks.
- Rows outside the image (row ≥ height) are zero-filled without DRAM traffic.

Parameters:
W_SIZE, 9, width of row/width/height fields
W_CHANNEL, 5, width of tiled-channel count
IFM_BUF_CNT, 4, number of line-buffer banks
W_IFM_BUF, 2, log2(IFM_BUF_CNT)
W_DATA, 32, DRAM beat and buffer word width
W_ADDR, 32, DRAM byte address width
W_BUF_ADDR, 10, per-bank word address width
BPW, 4, bytes per word
MAX_BURST, 256, max beats per DRAM read command
W_LEN, 9, width of burst length field (holds MAX_BURST)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
i_req_load  in  1  one-cycle load request
i_req_row  in  W_SIZE  row index to load
i_width  in  W_SIZE  row width in pixels
i_height  in  W_SIZE  image height
i_chn  in  W_CHANNEL  tiled channel count
i_base_addr  in  W_ADDR  DRAM byte address of row 0
o_busy  out  1  high from request accept until o_done inclusive
o_done  out  1  one-cycle pulse; row fully written
o_bank  out  W_IFM_BUF  bank of current/last load
o_rd_req  out  1  read command valid
i_rd_ack  in  1  read command accepted
o_rd_addr  out  W_ADDR  burst start byte address
o_rd_len  out  W_LEN  burst length in beats
i_rd_valid  in  1  read data valid
o_rd_ready  out  1  loader accepts data
i_rd_data  in  W_DATA  read data
o_buf_we  out  IFM_BUF_CNT  one-hot bank write enable
o_buf_addr  out  W_BUF_ADDR  bank word address
o_buf_wdata  out  W_DATA  write data

Behaviour:
- Reset: FSM=IDLE; all outputs 0; internal counters 0.
- Reset asserted mid-operation aborts immediately. No done is issued. The DRAM side is reset together with the loader.
- Derived quantities:
  - total = i_width × i_chn, latched.
  - bank = row[W_IDM_BUF-1:0], i.e. row mod IFM_BUF_CNT.
  - addr0 = base + row × total × BPW, computed at W_ADDR bits, modulo 2^W_ADDR.
- Constraint: total ≤ 2^W_BUF_ADDR. o_buf_addr wraps modulo its width otherwise.
- IDLE:
  - i_req_load latches row, width, height, chn, base and sets o_bank and o_busy.
  - If row ≥ height: go ZERO. Otherwise go CALC.
- CALC (1 cycle):
  - Compute total and addr0; clear word counter.
  - If total = 0: go DONE. Otherwise go CMD.
- CMD:
  - o_rd_req=1, o_rd_addr = current address, o_rd_len = min(remaining, MAX_BURST).
  - Address and length are held stable until i_rd_ack; the command transfers on the cycle where req&ack.
  - Then go DATA. If i_rd_ack is high on the first CMD cycle, CMD lasts exactly 1 cycle.
- DATA:
  - o_rd_ready=1. Each cycle with valid&ready accepts one beat.
  - Cycle t+1 after acceptance: o_buf_we[bank]=1, o_buf_addr = word counter, o_buf_wdata = beat. Counter then increments.
  - After the burst's last beat: if remaining = 0, go DONE. Otherwise advance the address by len × BPW and go CMD.
  - o_rd_ready drops in the cycle after the last beat is accepted.
- ZERO:
  - One zero write per cycle to bank, addresses 0..total-1, write strobe registered as in DATA.
  - Then go DONE. No o_rd_req is issued. total = 0 goes to DONE directly.
- DONE:
  - o_done=1 for exactly one cycle, coinciding with or after the last write strobe. The last strobe is never later than o_done.
  - o_busy falls the next cycle; then back to IDLE.
- Requests:
  - i_req_load while o_busy (including the DONE cycle) is ignored; no queueing.
  - A request on the cycle after DONE is accepted.
- Latency: request accepted in IDLE at cycle t gives o_rd_req at t+2.

Test Plan:
1. width=256, chn=4, height=256, base=0x1000_0000, row=0, ack and valid always high → 4 commands:
   - addresses 0x1000_0000, 0x1000_0400, 0x1000_0800, 0x1000_0C00, each len=256;
   - 1024 writes to bank 0, addresses 0..1023, data echoed;
   - single o_done pulse.
2. Same configuration, row=5 → first o_rd_addr=0x1000_5000, o_buf_we=4'b0010; row=3 → addr 0x1000_3000, we=4'b1000.
3. Row=256, height=256 → no o_rd_req; 1024 zero writes to bank 0; o_done after the last write.
4. Backpressure: i_rd_valid toggling 1/0 and i_rd_ack delayed 5 cycles → address/len held during wait; 1024 writes in order, no gaps or duplicates; exactly 4 commands; one o_done.
5. i_req_load pulsed mid-DATA and on the DONE cycle → ignored (o_bank unchanged, no extra commands); request one cycle after DONE → accepted.
6. rstn low mid-burst (beat 100) → all outputs 0 asynchronously, no o_done; a new request after release performs a full correct load.
